// File: rtl/systolic_pkg.sv
// Shared definitions for the skewed systolic array: controller state encoding,
// flush-length helper and row-index width helper.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Zero-injection cycles needed so the last beat reaches PE(N-1,N-1):
    // N-1 cycles of skew plus N-1 hops, plus one operand register stage.
    function automatic int flush_cycles(input int array_size);
        return 2 * array_size - 1;
    endfunction

    // Width of a row index; never zero so a 1-bit port still exists.
    function automatic int row_idx_width(input int array_size);
        return (array_size > 1) ? $clog2(array_size) : 1;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// Processing element: registers west/north operands, forwards them east/south and
// accumulates their signed product. Latency: operand in -> accumulator in 2 edges.
// Backpressure: none; acc_en_i freezes the accumulator, operands always advance.
//
// Ports: clk/rst (sync, active-high); clr_i zeroes operands and accumulator;
//        acc_en_i enables accumulation; west_i/north_i operands in;
//        east_o/south_o registered operands out; acc_o accumulator.
// Optional feature: SYSTOLIC_ACC_SATURATE_EN selects sticky saturating accumulate
// instead of two's-complement wrap.
module mac_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         acc_en_i,
    input  logic signed [DATA_WIDTH-1:0] west_i,
    input  logic signed [DATA_WIDTH-1:0] north_i,
    output logic signed [DATA_WIDTH-1:0] east_o,
    output logic signed [DATA_WIDTH-1:0] south_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;

    logic signed [DW-1:0]   west_q;
    logic signed [DW-1:0]   north_q;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;

    always_comb begin
        prod     = west_q * north_q;
        prod_ext = AW'(prod);
    end

`ifdef SYSTOLIC_ACC_SATURATE_EN
    // One extra bit catches overflow; once clamped the PE holds its limit
    // until the next clear so later products cannot pull it back in range.
    logic signed [AW:0] sum_wide;
    logic               sat_q;
    logic               sat_d;

    always_comb begin
        sum_wide = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};
        acc_d    = sum_wide[AW-1:0];
        sat_d    = sat_q;
        if (sat_q) begin
            acc_d = acc_q;
        end else if (sum_wide[AW] != sum_wide[AW-1]) begin
            sat_d = 1'b1;
            acc_d = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            sat_q <= 1'b0;
        end else if (acc_en_i) begin
            sat_q <= sat_d;
        end
    end
`else
    always_comb begin
        acc_d = acc_q + prod_ext;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            west_q  <= '0;
            north_q <= '0;
            acc_q   <= '0;
        end else begin
            west_q  <= west_i;
            north_q <= north_i;
            if (acc_en_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign east_o  = west_q;
    assign south_o = north_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/skewed_systolic_array.sv
// Output-stationary C = A x B engine: takes unskewed A columns / B rows, skews them
// internally, flushes, then streams result rows. Latency: 1 + k_len + (2N-1) + N cycles
// best case. Backpressure: in_ready only in FEED; out_ready stalls the row stream.
//
// Ports: clk/rst (sync, active-high); start + k_len launch a tile from IDLE;
//        in_valid/in_ready + west_inputs/north_inputs carry operand beats (row/col 0 in MSB);
//        out_valid/out_ready + out_row/results carry result rows (col 0 in MSB);
//        busy is high outside IDLE; done pulses after the last row handshake.
// Optional feature: SYSTOLIC_ACC_SATURATE_EN (see mac_pe) selects saturating accumulate.
module skewed_systolic_array
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int KLEN_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [KLEN_WIDTH-1:0]                k_len,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]     west_inputs,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]     north_inputs,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [row_idx_width(ARRAY_SIZE)-1:0] out_row,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]      results,
    output logic                                 busy,
    output logic                                 done
);

    localparam int N       = ARRAY_SIZE;
    localparam int DW      = DATA_WIDTH;
    localparam int AW      = ACC_WIDTH;
    localparam int RW      = row_idx_width(ARRAY_SIZE);
    localparam int FLUSH_N = flush_cycles(ARRAY_SIZE);
    localparam int FW      = $clog2(FLUSH_N + 1);

    state_e                state_q;
    logic [KLEN_WIDTH-1:0] klen_q;
    logic [KLEN_WIDTH-1:0] beat_q;
    logic [FW-1:0]         flush_q;
    logic [RW-1:0]         row_q;
    logic                  done_q;

    logic start_acc;
    logic beat_acc;
    logic acc_en;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign beat_acc  = (state_q == ST_FEED) && in_valid;
    assign acc_en    = (state_q == ST_FEED) || (state_q == ST_FLUSH);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        klen_q  <= k_len;
                        beat_q  <= '0;
                        flush_q <= '0;
                        row_q   <= '0;
                        // A zero-length tile still drains its all-zero rows.
                        state_q <= (k_len != '0) ? ST_FEED : ST_DRAIN;
                    end
                end
                ST_FEED: begin
                    if (in_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == klen_q - 1'b1) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == FW'(FLUSH_N - 1)) begin
                        flush_q <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (row_q == RW'(N - 1)) begin
                            row_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand injection: a bubble or non-FEED cycle injects zeros, which
    // multiply to nothing regardless of how they line up in the grid.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] w_inj  [N];
    logic signed [DW-1:0] n_inj  [N];
    logic signed [DW-1:0] w_skew [N];
    logic signed [DW-1:0] n_skew [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_inj[i] = '0;
            n_inj[i] = '0;
            if (beat_acc) begin
                w_inj[i] = west_inputs[(N-1-i)*DW +: DW];
                n_inj[i] = north_inputs[(N-1-i)*DW +: DW];
            end
        end
    end

    // Row/column i is delayed i cycles so A[i][k] and B[k][j] meet in PE(i,j).
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign w_skew[gi] = w_inj[gi];
            assign n_skew[gi] = n_inj[gi];
        end else begin : g_line
            logic signed [DW-1:0] wl_q [gi];
            logic signed [DW-1:0] nl_q [gi];

            always_ff @(posedge clk) begin
                if (rst || start_acc) begin
                    for (int k = 0; k < gi; k++) begin
                        wl_q[k] <= '0;
                        nl_q[k] <= '0;
                    end
                end else begin
                    wl_q[0] <= w_inj[gi];
                    nl_q[0] <= n_inj[gi];
                    for (int k = 1; k < gi; k++) begin
                        wl_q[k] <= wl_q[k-1];
                        nl_q[k] <= nl_q[k-1];
                    end
                end
            end

            assign w_skew[gi] = wl_q[gi-1];
            assign n_skew[gi] = nl_q[gi-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
    logic signed [DW-1:0] h_bus [N][N+1];
    logic signed [DW-1:0] v_bus [N+1][N];
    logic signed [AW-1:0] acc_m [N][N];

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign h_bus[gi][0] = w_skew[gi];
        assign v_bus[0][gi] = n_skew[gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_pe #(
                .DATA_WIDTH (DW),
                .ACC_WIDTH  (AW)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .clr_i    (start_acc),
                .acc_en_i (acc_en),
                .west_i   (h_bus[gi][gj]),
                .north_i  (v_bus[gi][gj]),
                .east_o   (h_bus[gi][gj+1]),
                .south_o  (v_bus[gi+1][gj]),
                .acc_o    (acc_m[gi][gj])
            );
        end
    end

    // Operands falling off the east/south edges are discarded.
    logic unused_edges;
    always_comb begin
        unused_edges = 1'b0;
        for (int k = 0; k < N; k++) begin
            unused_edges = unused_edges ^ (^h_bus[k][N]) ^ (^v_bus[N][k]);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_FEED);
    assign out_valid = (state_q == ST_DRAIN);
    assign busy      = (state_q != ST_IDLE);
    assign out_row   = row_q;
    assign done      = done_q;

    always_comb begin
        results = '0;
        if (state_q == ST_DRAIN) begin
            for (int j = 0; j < N; j++) begin
                results[(N-1-j)*AW +: AW] = acc_m[row_q][j];
            end
        end
    end

endmodule

// File: tb/tb_skewed_systolic_array.sv
// Directed bench for skewed_systolic_array at N=4, 16-bit operands, 32-bit results.
// Latency: each tile is timed from start to done. Backpressure: exercises in_valid
// bubbles and out_ready stalls.
module tb_skewed_systolic_array;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      k_len;
    logic             in_valid;
    logic             in_ready;
    logic [N*DW-1:0]  west_inputs;
    logic [N*DW-1:0]  north_inputs;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_row;
    logic [N*AW-1:0]  results;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    skewed_systolic_array #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .KLEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .west_inputs  (west_inputs),
        .north_inputs (north_inputs),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .results      (results),
        .busy         (busy),
        .done         (done)
    );

    int n_vec = 0;
    int n_err = 0;

    int a_m [4][4];
    int b_m [4][4];
    int e_m [4][4];
    bit use_const = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v;
        int           e;
        v = '0;
        for (int j = 0; j < N; j++) begin
            e = e_m[r][j];
            v[(N-1-j)*AW +: AW] = e[31:0];
        end
        return v;
    endfunction

    task automatic drive_beat(input int b);
        int av;
        int bv;
        for (int i = 0; i < N; i++) begin
            av = use_const ? -32768 : a_m[i][b];
            bv = use_const ? -32768 : b_m[b][i];
            west_inputs[(N-1-i)*DW +: DW]  = av[15:0];
            north_inputs[(N-1-i)*DW +: DW] = bv[15:0];
        end
    endtask

    // Entered at a falling edge; start is asserted in that cycle (C0). Returns at the
    // falling edge of the done cycle so the caller may start again back-to-back.
    task automatic run_tile(input int klen, input bit toggle, input int hold_row,
                            input int want_cyc, input int want_feed, input string tag);
        int cyc;
        int feed;
        int row;
        int held;
        int beat;
        bit vld_ph;
        bit seen_done;
        start     = 1'b1;
        k_len     = klen[15:0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_beat(0);
        vld_ph    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        feed      = 0;
        row       = 0;
        held      = 0;
        beat      = 0;
        seen_done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            in_valid     = 1'b0;
            west_inputs  = '0;
            north_inputs = '0;
            if (in_ready) begin
                feed++;
                vld_ph = toggle ? !vld_ph : 1'b1;
                if (vld_ph) begin
                    in_valid = 1'b1;
                    drive_beat(beat);
                    beat++;
                end
            end
            out_ready = 1'b1;
            if (out_valid) begin
                check({tag, "_row"}, 128'(out_row), 128'(row));
                check({tag, "_res"}, results, exp_row(row));
                if (row == hold_row && held < 5) begin
                    out_ready = 1'b0;
                    held++;
                end else begin
                    row++;
                end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_done_seen"}, 128'(seen_done), 128'(1));
        check({tag, "_latency"}, 128'(cyc), 128'(want_cyc));
        check({tag, "_feed_cycles"}, 128'(feed), 128'(want_feed));
        check({tag, "_rows"}, 128'(row), 128'(N));
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        k_len        = '0;
        in_valid     = 1'b0;
        west_inputs  = '0;
        north_inputs = '0;
        out_ready    = 1'b0;

        b_m = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 16}};
        a_m = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
        e_m = b_m;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {in_ready, out_valid, out_row, busy, done}, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_ctrl", {in_ready, out_valid, out_row, busy, done}, 128'd0);
        check("idle_results", results, 128'd0);

        // Identity A: result rows equal B.
        run_tile(4, 1'b0, -1, 16, 4, "ident");

        // Same tile with in_valid bubbles, started back-to-back in the done cycle.
        run_tile(4, 1'b1, -1, 20, 8, "gap");

        // Mixed signed A, row 2 held for five cycles.
        a_m = '{'{1, 1, 1, 1}, '{-1, 0, 0, 0}, '{0, 0, 2, 0}, '{0, 1, 0, -1}};
        e_m = '{'{28, 32, 36, 40}, '{-1, -2, -3, -4}, '{18, 20, 22, 24}, '{-8, -8, -8, -8}};
        @(negedge clk);
        run_tile(4, 1'b0, 2, 21, 4, "hold");

        // Zero reduction length drains zeros.
        e_m = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        @(negedge clk);
        run_tile(0, 1'b0, -1, 5, 0, "kzero");

        // 256 beats of (-32768)^2 = 2^30 each; total 2^38.
        use_const = 1'b1;
`ifdef SYSTOLIC_ACC_SATURATE_EN
        e_m = '{'{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
                '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
                '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
                '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}};
`else
        e_m = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
`endif
        @(negedge clk);
        run_tile(256, 1'b0, -1, 268, 256, "sat");
        use_const = 1'b0;

        // Abort a mixed-A tile in FLUSH, then an identity tile must be clean.
        @(negedge clk);
        start     = 1'b1;
        k_len     = 16'd4;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid     = 1'b0;
        west_inputs  = '0;
        north_inputs = '0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("flush_state", {in_ready, out_valid, busy}, 128'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctrl", {in_ready, out_valid, out_row, busy, done}, 128'd0);
        check("abort_results", results, 128'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_idle", {out_valid, busy, done}, 128'd0);

        a_m = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
        e_m = b_m;
        run_tile(4, 1'b0, -1, 16, 4, "post_abort");

        @(posedge clk);
        @(negedge clk);
        check("final_idle", {busy, done, out_valid}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skewed_systolic_array.md
# skewed_systolic_array

Output-stationary signed-integer matrix-multiply engine for the accelerator datapath. It computes C = A×B for square ARRAY_SIZE tiles over a programmable reduction length. It accepts one unskewed A column / B row per beat over a valid/ready stream, skews the operands internally, runs its own feed/flush/drain sequencing, and streams results out one row per handshake. It supersedes the bare PE grid: the host no longer pre-skews inputs, counts flush cycles or indexes rows.

## Interface
- ARRAY_SIZE, 16: grid is ARRAY_SIZE×ARRAY_SIZE; ≥2
- DATA_WIDTH, 16: signed operand width
- ACC_WIDTH, 40: signed accumulator/result element width; ≥2*DATA_WIDTH
- KLEN_WIDTH, 16: width of k_len
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KLEN_WIDTH  reduction length, latched on accepted start
- in_valid  in  1  operand beat valid
- in_ready  out  1  high exactly while in FEED
- west_inputs  in  ARRAY_SIZE*DATA_WIDTH  A column; row 0 in MSB slice
- north_inputs  in  ARRAY_SIZE*DATA_WIDTH  B row; column 0 in MSB slice
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts row
- out_row  out  clog2(ARRAY_SIZE)  index of presented row
- results  out  ARRAY_SIZE*ACC_WIDTH  C[out_row][*]; column 0 in MSB slice; zero when out_valid low
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last row handshake

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE: start=1 latches k_len, zeroes all accumulators and skew registers, sets beat counter to 0. Next state FEED if k_len≠0, else DRAIN (drains all-zero tile).
- FEED: beat accepted on in_valid&&in_ready; counter increments. A cycle without in_valid injects zero into every skew line (bubble). Zero-zero pairs stay aligned, so bubbles never corrupt results. After beat k_len-1 is accepted → FLUSH.
- Skew: west slice i is delayed i cycles, north slice j is delayed j cycles, each by a register chain. Operands then propagate east/south one PE per cycle, as before.
- PE(i,j): acc += sext(west*north) when accumulating. Product is 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH. Wraps modulo 2^ACC_WIDTH by default.
- FLUSH: zeros injected for exactly 2*ARRAY_SIZE-1 cycles → DRAIN.
- DRAIN: accumulation frozen. Row counter starts at 0. out_valid=1, out_row=counter, results=row accumulators. On out_valid&&out_ready the counter increments. Handshake on row ARRAY_SIZE-1 → done=1 for that next cycle, state IDLE.
- start outside IDLE is ignored. in_valid outside FEED is ignored.

## Timing
- Reset: state IDLE, accumulators, skew registers and counters zero. Outputs: in_ready 0, out_valid 0, out_row 0, results 0, busy 0, done 0.
- rst mid-tile (any state) aborts the tile. Same values apply the next cycle, and no done pulse is issued.
- start accepted at edge E: busy=1 from E; FEED, in_ready=1 from E.
- Beat accepted at edge E: its contribution enters PE(i,j) accumulator at edge E+1+i+j. The last beat is complete in PE(N-1,N-1) by the final FLUSH edge.
- First DRAIN cycle: out_valid=1 combinationally from state, with no extra cycle.
- out_valid, out_row and results stay stable while out_ready=0.
- Best-case latency from start to done: 1 + k_len + (2*ARRAY_SIZE-1) + ARRAY_SIZE cycles.
- Back-to-back operation: start may be asserted in the cycle where done=1 (state is IDLE).

## Configuration
- SYSTOLIC_ACC_SATURATE_EN defined: each accumulate clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and sticks at the limit until cleared by start or rst.
- SYSTOLIC_ACC_SATURATE_EN undefined: two's-complement wrap.

## Structure
- Package systolic_pkg holds:
  - state encoding (IDLE/FEED/FLUSH/DRAIN)
  - FLUSH_CYCLES = 2*ARRAY_SIZE-1 helper
  - row-index width function
- Sub-module mac_pe holds the operand pass-through registers, multiply, sign-extend, accumulate and optional saturation. The top level holds the FSM, counters, skew lines and output mux.

## Test plan
- ARRAY_SIZE=4, k_len=4, A=I, B=[1..16] row-major, in_valid held high → rows drain as B, out_row 0..3; done 1 + 4 + 7 + 4 = 16 cycles after start.
- Same tile with in_valid toggling 1,0,1,0 → identical results; FEED lasts 8 cycles.
- k_len=0 → DRAIN immediately; 4 rows of zeros; done after the 4th handshake.
- out_ready low for 5 cycles on row 2 → out_row=2, results unchanged throughout; row 3 follows the release.
- All operands −32768, k_len=2^8, ACC_WIDTH=32 with the macro → every element 0x7FFFFFFF. Without the macro → every element equals 2^38 mod 2^32 = 0.
- rst asserted during FLUSH → next cycle busy=0, out_valid=0; a new start then yields the correct result with no residue from the aborted tile.
